// File: rtl/tc_event_monitor.sv
// tc_event_monitor
//   Watches a counter's terminal-count flag and value. Rising edges of tc_in
//   (while enabled) advance an auto-reload event counter that raises a sticky
//   interrupt every `thresh` events. Capture strobes snapshot y_in into a
//   first-word-fall-through FIFO drained through a valid/ready handshake.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   en            gates event detection and capture
//   tc_in, y_in   monitored terminal-count flag and counter value
//   thresh        events per interrupt (0 = free-run, no interrupt)
//   irq_clr       clears irq (a simultaneous threshold hit wins)
//   cap           push y_in into the snapshot FIFO
//   snap_ready    consumer ready; a pop occurs on snap_valid & snap_ready
//   snap_valid    FIFO non-empty
//   snap_data     FIFO head, zero when empty
//   fifo_cnt      number of entries held
//   evt_cnt       event counter
//   irq/ovf/drop  sticky interrupt / counter wrapped / capture lost
module tc_event_monitor #(
  parameter int CNT_W      = 4,
  parameter int EVT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          tc_in,
  input  logic [CNT_W-1:0]              y_in,
  input  logic [EVT_W-1:0]              thresh,
  input  logic                          irq_clr,
  input  logic                          cap,
  input  logic                          snap_ready,
  output logic                          snap_valid,
  output logic [CNT_W-1:0]              snap_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic [EVT_W-1:0]              evt_cnt,
  output logic                          irq,
  output logic                          ovf,
  output logic                          drop
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic             r_tc_q;
  logic [EVT_W-1:0] r_evt_cnt;
  logic             r_irq;
  logic             r_ovf;
  logic             r_drop;

  logic [CNT_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cnt;

  logic             w_rise;
  logic [EVT_W:0]   w_evt_inc;
  logic             w_hit;
  logic             w_empty;
  logic             w_full;
  logic             w_push_req;
  logic             w_push;
  logic             w_pop;

  always_comb begin
    w_rise     = en & tc_in & ~r_tc_q;
    // Extra carry bit exposes the wrap; thresh can never equal 2^EVT_W.
    w_evt_inc  = {1'b0, r_evt_cnt} + {{EVT_W{1'b0}}, 1'b1};
    w_hit      = (thresh != '0) && (w_evt_inc == {1'b0, thresh});
    w_empty    = (r_cnt == '0);
    w_full     = (r_cnt == CW'(FIFO_DEPTH));
    w_push_req = en & cap;
    w_pop      = ~w_empty & snap_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    w_push     = w_push_req & (~w_full | w_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tc_q    <= 1'b1;
      r_evt_cnt <= '0;
      r_irq     <= 1'b0;
      r_ovf     <= 1'b0;
      r_drop    <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
    end else begin
      r_tc_q <= tc_in;

      if (w_rise && w_hit) begin
        r_evt_cnt <= '0;
        r_irq     <= 1'b1;
      end else begin
        if (w_rise) begin
          r_evt_cnt <= w_evt_inc[EVT_W-1:0];
          if (w_evt_inc[EVT_W]) r_ovf <= 1'b1;
        end
        if (irq_clr) r_irq <= 1'b0;
      end

      if (w_push_req && !w_push) r_drop <= 1'b1;

      if (w_push) begin
        r_mem[r_wr_ptr] <= y_in;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign snap_valid = ~w_empty;
  assign snap_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign fifo_cnt   = r_cnt;
  assign evt_cnt    = r_evt_cnt;
  assign irq        = r_irq;
  assign ovf        = r_ovf;
  assign drop       = r_drop;

endmodule

// File: tb/tb_tc_event_monitor.sv
// Testbench for tc_event_monitor: directed stimulus; FIFO output checked by a
// scoreboard queue popped by an independent monitor, status checked directly.
module tb_tc_event_monitor;

  localparam int CNT_W = 4;
  localparam int EVT_W = 8;
  localparam int DEPTH = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    en;
  logic                    tc_in;
  logic [CNT_W-1:0]        y_in;
  logic [EVT_W-1:0]        thresh;
  logic                    irq_clr;
  logic                    cap;
  logic                    snap_ready;
  logic                    snap_valid;
  logic [CNT_W-1:0]        snap_data;
  logic [$clog2(DEPTH):0]  fifo_cnt;
  logic [EVT_W-1:0]        evt_cnt;
  logic                    irq;
  logic                    ovf;
  logic                    drop;

  int checks   = 0;
  int failures = 0;
  int sbq[$];

  tc_event_monitor #(.CNT_W(CNT_W), .EVT_W(EVT_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .tc_in(tc_in), .y_in(y_in),
    .thresh(thresh), .irq_clr(irq_clr), .cap(cap), .snap_ready(snap_ready),
    .snap_valid(snap_valid), .snap_data(snap_data), .fifo_cnt(fifo_cnt),
    .evt_cnt(evt_cnt), .irq(irq), .ovf(ovf), .drop(drop)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  // Monitor: a handshake seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!rst && snap_valid && snap_ready) begin
      chk("sb_expected_entry", int'(sbq.size() != 0), 1);
      if (sbq.size() != 0) chk("snap_data", int'(snap_data), sbq.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    tc_in = 1'b1; tick();
    tc_in = 1'b0; tick();
  endtask

  task automatic capture(input int v, input bit expect_stored);
    y_in = CNT_W'(v); cap = 1'b1;
    if (expect_stored) sbq.push_back(v);
    tick();
    cap = 1'b0;
  endtask

  task automatic drain();
    snap_ready = 1'b1;
    for (int k = 0; k < 12 && snap_valid; k++) tick();
    chk("drain_valid", int'(snap_valid), 0);
    chk("drain_sb_empty", sbq.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  int exp_evt[7] = '{1, 2, 0, 1, 2, 0, 1};

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; tc_in = 1'b0; y_in = '0; thresh = 8'd3;
    irq_clr = 1'b0; cap = 1'b0; snap_ready = 1'b0;
    tick(); tick();
    chk("rst_evt_cnt", evt_cnt, 0);
    chk("rst_irq", irq, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop", drop, 0);
    chk("rst_valid", snap_valid, 0);
    chk("rst_fifo_cnt", fifo_cnt, 0);
    chk("rst_snap_data", snap_data, 0);
    rst = 1'b0; en = 1'b1; tick();

    // 1: thresh=3 reload and sticky irq
    for (int i = 0; i < 7; i++) begin
      pulse();
      chk("t1_evt_cnt", evt_cnt, exp_evt[i]);
      chk("t1_irq", irq, (i >= 2) ? 1 : 0);
    end
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    chk("t1_irq_clr", irq, 0);

    // 2: level high counts once; high at reset release / enable rise counts none
    thresh = 8'd0;
    tc_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    tc_in = 1'b0; tick();
    chk("t2_held_high", evt_cnt, 2);
    rst = 1'b1; tc_in = 1'b1; tick(); rst = 1'b0;
    tick(); tick();
    tc_in = 1'b0; tick();
    chk("t2_high_at_rst_release", evt_cnt, 0);
    en = 1'b0; tc_in = 1'b1; tick();
    en = 1'b1; tick(); tick();
    tc_in = 1'b0; tick();
    chk("t2_en_rise_while_high", evt_cnt, 0);

    // 3: free-run wrap
    for (int i = 0; i < 255; i++) pulse();
    chk("t3_evt_255", evt_cnt, 255);
    chk("t3_ovf_before_wrap", ovf, 0);
    pulse();
    chk("t3_evt_wrap", evt_cnt, 0);
    chk("t3_ovf", ovf, 1);
    chk("t3_irq", irq, 0);

    // 4: overfill, then drain in order
    snap_ready = 1'b0;
    for (int v = 5; v <= 9; v++) capture(v, v <= 8);
    chk("t4_fifo_cnt", fifo_cnt, 4);
    chk("t4_drop", drop, 1);
    chk("t4_head", snap_data, 5);
    tick();
    chk("t4_head_stable", snap_data, 5);
    drain();
    // empty FIFO with ready high: entry appears, no pop at push edge
    capture(3, 1'b1);
    chk("t4_empty_push_cnt", fifo_cnt, 1);
    chk("t4_empty_push_valid", snap_valid, 1);
    tick();
    chk("t4_after_pop_cnt", fifo_cnt, 0);

    // 5: full FIFO, push and pop same cycle
    snap_ready = 1'b0;
    do_reset();
    for (int v = 1; v <= 4; v++) capture(v, 1'b1);
    snap_ready = 1'b1;
    capture(10, 1'b1);
    snap_ready = 1'b0;
    chk("t5_fifo_cnt", fifo_cnt, 4);
    chk("t5_no_drop", drop, 0);
    drain();
    // irq_clr coincident with threshold hit
    thresh = 8'd2;
    pulse();
    tc_in = 1'b1; irq_clr = 1'b1; tick();
    tc_in = 1'b0; irq_clr = 1'b0;
    chk("t5_set_wins_irq", irq, 1);
    chk("t5_set_wins_evt", evt_cnt, 0);
    tick();

    // 6: reset mid-operation flushes everything
    thresh = 8'd5;
    pulse(); pulse();
    snap_ready = 1'b0;
    for (int v = 1; v <= 3; v++) capture(v, 1'b1);
    chk("t6_pre_cnt", fifo_cnt, 3);
    chk("t6_pre_evt", evt_cnt, 2);
    chk("t6_pre_irq", irq, 1);
    do_reset();
    sbq.delete();
    chk("t6_evt", evt_cnt, 0);
    chk("t6_irq", irq, 0);
    chk("t6_ovf", ovf, 0);
    chk("t6_fifo_cnt", fifo_cnt, 0);
    chk("t6_valid", snap_valid, 0);
    chk("t6_data", snap_data, 0);
    // en=0 suppresses events and captures
    en = 1'b0; thresh = 8'd1;
    pulse(); pulse(); pulse();
    capture(7, 1'b0);
    tick();
    chk("t6_dis_evt", evt_cnt, 0);
    chk("t6_dis_irq", irq, 0);
    chk("t6_dis_cnt", fifo_cnt, 0);
    chk("t6_dis_drop", drop, 0);

    chk("final_sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
